shift_arbiter: RTL



---
 rtl/shift_arb_pkg.sv | 21 ++
 rtl/shift_arbiter_if.sv | 40 ++++
 rtl/shift_arb_pick.sv | 38 +++
 rtl/shift_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the EX-stage shifter arbiter.
// Arbitration mode is selected by SHIFT_ARB_RR_EN (see shift_arb_pick).
package shift_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } shift_arb_state_t;

  localparam logic [2:0] SRL_OP     = 3'b011;
  localparam logic [2:0] SH_IDLE_OP = 3'b000;

  function automatic logic [1:0] portOneHot(input logic portIdx);
    return portIdx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response and shifter-side bus of the shift arbiter.
// slave = arbiter view, master = requesters plus shifter view.
interface shift_arbiter_if
  import shift_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [DATA_W-1:0]  req0_data;
  logic [DATA_W-1:0]  req1_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [2:0]         req0_op;
  logic [2:0]         req1_op;

  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [DATA_W-1:0]  resp_data;

  logic [DATA_W-1:0]  sh_dataA;
  logic [SHAMT_W-1:0] sh_dataB;
  logic [2:0]         sh_signal;
  logic [DATA_W-1:0]  sh_dataOut;

  modport slave (
    input  req_valid, req0_data, req1_data, req0_shamt, req1_shamt,
           req0_op, req1_op, resp_ready, sh_dataOut,
    output req_ready, resp_valid, resp_data, sh_dataA, sh_dataB, sh_signal
  );

  modport master (
    output req_valid, req0_data, req1_data, req0_shamt, req1_shamt,
           req0_op, req1_op, resp_ready, sh_dataOut,
    input  req_ready, resp_valid, resp_data, sh_dataA, sh_dataB, sh_signal
  );

endinterface

// File: rtl/shift_arb_pick.sv
// Combinational one-hot grant for the two shifter requesters.
// SHIFT_ARB_RR_EN defined: round-robin on last grant; undefined: port 0 fixed priority.
module shift_arb_pick (
  input  logic [1:0] reqValid,
  input  logic       lastGrant,
  input  logic       enable,
  output logic [1:0] grant
);

`ifdef SHIFT_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (reqValid == 2'b11) begin
        grant = lastGrant ? 2'b01 : 2'b10;
      end else begin
        grant = reqValid;
      end
    end
  end
`else
  // History is still tracked by the caller; fixed priority ignores it.
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (reqValid[0]) begin
        grant = 2'b01;
      end else if (reqValid[1]) begin
        grant = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter/sequencer for the shared EX-stage barrel shifter, one request in flight.
// Arbitration policy comes from shift_arb_pick (macro SHIFT_ARB_RR_EN).
//
//   state | meaning
//   IDLE  | grant offered combinationally, operands captured on accept
//   SHIFT | shifter driven from operand registers, result captured
//   RESP  | result presented to owner until it takes it
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus,
  output logic           busy
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_RESP  = 2'(RESP);

  logic [1:0]         stateQ;
  logic [DATA_W-1:0]  dataQ;
  logic [SHAMT_W-1:0] shamtQ;
  logic [2:0]         opQ;
  logic [DATA_W-1:0]  resultQ;
  logic               ownerQ;
  logic               lastGrantQ;

  logic [1:0]         grant;
  logic               grantIdx;
  logic               pickEn;
  logic               inShift;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign pickEn   = rst_n && (stateQ == ST_IDLE);
  assign grantIdx = grant[1];
  assign inShift  = (stateQ == ST_SHIFT);

  shift_arb_pick uPick (
    .reqValid  (bus.req_valid),
    .lastGrant (lastGrantQ),
    .enable    (pickEn),
    .grant     (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= ST_IDLE;
      dataQ      <= '0;
      shamtQ     <= '0;
      opQ        <= SH_IDLE_OP;
      resultQ    <= '0;
      ownerQ     <= 1'b0;
      lastGrantQ <= 1'b1;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (|grant) begin
            dataQ      <= grantIdx ? bus.req1_data  : bus.req0_data;
            shamtQ     <= grantIdx ? bus.req1_shamt : bus.req0_shamt;
            opQ        <= grantIdx ? bus.req1_op    : bus.req0_op;
            ownerQ     <= grantIdx;
            lastGrantQ <= grantIdx;
            stateQ     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Non-SRL ops complete normally but always return zero.
          resultQ <= (opQ == SRL_OP) ? bus.sh_dataOut : '0;
          stateQ  <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready[ownerQ]) begin
            stateQ <= ST_IDLE;
          end
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (stateQ == ST_RESP) ? portOneHot(ownerQ) : 2'b00;
  assign bus.resp_data  = resultQ;

  // Zero shifter inputs outside SHIFT so the shared shifter stays quiet.
  assign bus.sh_dataA  = inShift ? dataQ  : '0;
  assign bus.sh_dataB  = inShift ? shamtQ : '0;
  assign bus.sh_signal = inShift ? opQ    : SH_IDLE_OP;

  assign busy = (stateQ != ST_IDLE);

endmodule
